ahb_copy_master: RTL and testbench



---
 rtl/ahb_copy_master.sv | 158 +++++++++++++++
 tb/tb_ahb_copy_master.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_copy_master.sv
// AHB-Lite master that copies a block of 32-bit words from a source range to a
// destination range using non-overlapped SINGLE word transfers (read, then write).
module ahb_copy_master #(
    parameter int LEN_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [3:0]       HPROT,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RA,
        S_RD,
        S_WA,
        S_WD,
        S_FIN
    } state_t;

    state_t           r_state,   w_state_nxt;
    logic [31:0]      r_src_ptr, w_src_nxt;
    logic [31:0]      r_dst_ptr, w_dst_nxt;
    logic [31:0]      r_buf,     w_buf_nxt;
    logic [31:0]      r_haddr,   w_haddr_nxt;
    logic [LEN_W-1:0] r_count,   w_count_nxt;
    logic             r_hwrite,  w_hwrite_nxt;
    logic             r_error,   w_error_nxt;

    // Word alignment is forced, so the low address bits never reach the bus.
    logic w_unused;
    assign w_unused = ^{src_addr[1:0], dst_addr[1:0]};

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path infers a latch.
        w_state_nxt  = r_state;
        w_src_nxt    = r_src_ptr;
        w_dst_nxt    = r_dst_ptr;
        w_buf_nxt    = r_buf;
        w_haddr_nxt  = r_haddr;
        w_count_nxt  = r_count;
        w_hwrite_nxt = r_hwrite;
        w_error_nxt  = r_error;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_src_nxt   = {src_addr[31:2], 2'b00};
                    w_dst_nxt   = {dst_addr[31:2], 2'b00};
                    w_count_nxt = len;
                    w_error_nxt = 1'b0;
                    if (len != '0) begin
                        w_state_nxt  = S_RA;
                        w_haddr_nxt  = {src_addr[31:2], 2'b00};
                        w_hwrite_nxt = 1'b0;
                    end else begin
                        w_state_nxt = S_FIN;
                    end
                end
            end
            S_RA: begin
                if (HREADY) w_state_nxt = S_RD;
            end
            S_RD: begin
                if (HREADY) begin
                    if (HRESP) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = S_FIN;
                    end else begin
                        w_buf_nxt    = HRDATA;
                        w_state_nxt  = S_WA;
                        w_haddr_nxt  = r_dst_ptr;
                        w_hwrite_nxt = 1'b1;
                    end
                end
            end
            S_WA: begin
                if (HREADY) w_state_nxt = S_WD;
            end
            S_WD: begin
                if (HREADY) begin
                    if (HRESP) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = S_FIN;
                    end else begin
                        w_src_nxt   = r_src_ptr + 32'd4;
                        w_dst_nxt   = r_dst_ptr + 32'd4;
                        w_count_nxt = r_count - LEN_W'(1);
                        // The count test uses the pre-decrement value: 1 means this was the last word.
                        if (r_count == LEN_W'(1)) begin
                            w_state_nxt = S_FIN;
                        end else begin
                            w_state_nxt  = S_RA;
                            w_haddr_nxt  = r_src_ptr + 32'd4;
                            w_hwrite_nxt = 1'b0;
                        end
                    end
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= S_IDLE;
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_buf     <= '0;
            r_haddr   <= '0;
            r_count   <= '0;
            r_hwrite  <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_state   <= w_state_nxt;
            r_src_ptr <= w_src_nxt;
            r_dst_ptr <= w_dst_nxt;
            r_buf     <= w_buf_nxt;
            r_haddr   <= w_haddr_nxt;
            r_count   <= w_count_nxt;
            r_hwrite  <= w_hwrite_nxt;
            r_error   <= w_error_nxt;
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_FIN);
    assign error  = r_error;
    assign HTRANS = (r_state == S_RA || r_state == S_WA) ? 2'b10 : 2'b00;
    assign HADDR  = r_haddr;
    assign HWRITE = r_hwrite;
    assign HWDATA = r_buf;
    assign HSIZE  = 3'b010;
    assign HBURST = 3'b000;
    assign HPROT  = 4'b0011;

endmodule

// File: tb/tb_ahb_copy_master.sv
// Bench for ahb_copy_master: AHB-Lite slave model with configurable waits and
// ERROR injection, a transfer-level reference model, table and random runs.
module tb_ahb_copy_master;

    localparam int LEN_W = 16;
    localparam int MAXC  = 256;

    logic             HCLK;
    logic             HRESETn;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             error;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic [2:0]       HSIZE;
    logic [2:0]       HBURST;
    logic [3:0]       HPROT;
    logic [31:0]      HWDATA;
    logic [31:0]      HRDATA;
    logic             HREADY;
    logic             HRESP;

    ahb_copy_master #(.LEN_W(LEN_W)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HBURST   (HBURST),
        .HPROT    (HPROT),
        .HWDATA   (HWDATA),
        .HRDATA   (HRDATA),
        .HREADY   (HREADY),
        .HRESP    (HRESP)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    int    n_vec = 0;
    int    n_err = 0;
    string cur_tag = "reset";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got 0x%0h, expected 0x%0h", cur_tag, name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        logic        err;
    } xfer_t;

    logic [31:0] mem [logic [31:0]];
    xfer_t       log_q[$];
    int          wait_n = 0;
    int          err_at = -1;

    function automatic int ph_waits(input bit e);
        return e ? ((wait_n < 1) ? 1 : wait_n) : wait_n;
    endfunction

    initial begin : slave
        bit          dp_active;
        logic [31:0] dp_addr;
        bit          dp_wr;
        bit          dp_err;
        int          dp_left;
        int          phase_idx;
        dp_active = 1'b0;
        dp_addr   = '0;
        dp_wr     = 1'b0;
        dp_err    = 1'b0;
        dp_left   = 0;
        phase_idx = 0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                dp_active = 1'b0;
                HREADY    = 1'b1;
                HRESP     = 1'b0;
            end else begin
                if (!busy) phase_idx = 0;
                if (dp_active) begin
                    if (dp_left > 0) begin
                        HREADY = 1'b0;
                        HRESP  = dp_err && (dp_left == 1);
                        dp_left--;
                    end else begin
                        HREADY = 1'b1;
                        HRESP  = dp_err;
                        if (!dp_wr)
                            HRDATA = dp_err ? 32'hBAD0_BAD0 : (mem.exists(dp_addr) ? mem[dp_addr] : 32'h0);
                        else if (!dp_err)
                            mem[dp_addr] = HWDATA;
                        log_q.push_back('{dp_addr, dp_wr, dp_wr ? HWDATA : HRDATA, dp_err});
                        dp_active = 1'b0;
                    end
                end else begin
                    HREADY = 1'b1;
                    HRESP  = 1'b0;
                end
                if (HREADY && HTRANS == 2'b10) begin
                    dp_active = 1'b1;
                    dp_addr   = HADDR;
                    dp_wr     = HWRITE;
                    dp_err    = (phase_idx == err_at);
                    dp_left   = ph_waits(dp_err);
                    phase_idx++;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        logic        err;
        int          waits;
    } phase_t;

    phase_t      exp_q[$];
    logic [31:0] model_mem [logic [31:0]];

    task automatic build_model(input logic [31:0] s, input logic [31:0] d, input int n,
                               output int exp_done, output bit exp_err);
        logic [31:0] s4, d4, ra, wa, data;
        bit          e;
        exp_q.delete();
        exp_err = 1'b0;
        s4 = {s[31:2], 2'b00};
        d4 = {d[31:2], 2'b00};
        for (int i = 0; i < n && !exp_err; i++) begin
            ra   = s4 + 32'(4 * i);
            data = model_mem.exists(ra) ? model_mem[ra] : 32'h0;
            e    = (2 * i == err_at);
            exp_q.push_back('{ra, 1'b0, data, e, ph_waits(e)});
            if (e) begin
                exp_err = 1'b1;
            end else begin
                wa = d4 + 32'(4 * i);
                e  = (2 * i + 1 == err_at);
                exp_q.push_back('{wa, 1'b1, data, e, ph_waits(e)});
                if (e) exp_err = 1'b1;
                else   model_mem[wa] = data;
            end
        end
        exp_done = 1;
        foreach (exp_q[p]) exp_done += 2 + exp_q[p].waits;
    endtask

    task automatic preload(input logic [31:0] s, input int n, input logic [31:0] d0);
        logic [31:0] s4;
        s4 = {s[31:2], 2'b00};
        for (int i = 0; i < n; i++) mem[s4 + 32'(4 * i)] = d0 + 32'(i);
    endtask

    // ---------------- run one command and compare ----------------
    logic [1:0]  tr_htrans [MAXC];
    logic [31:0] tr_haddr  [MAXC];
    logic [31:0] tr_hwdata [MAXC];
    logic        tr_hwrite [MAXC];
    logic        tr_busy   [MAXC];
    logic        tr_done   [MAXC];
    logic        tr_error  [MAXC];

    task automatic run_and_check(input logic [31:0] s, input logic [31:0] d, input int n,
                                 input bit hold, input int exp_done, input bit exp_err);
        int base, win, cyc, done_cyc, n_done, n_busy, bad, n_cmp;
        base = log_q.size();
        win  = exp_done + 3;
        @(negedge HCLK);
        src_addr = s;
        dst_addr = d;
        len      = LEN_W'(n);
        start    = 1'b1;
        for (int c = 1; c <= win; c++) begin
            @(negedge HCLK);
            if (hold && c == 1) begin
                src_addr = 32'h100;
                dst_addr = 32'h200;
                len      = LEN_W'(1);
            end else begin
                start = 1'b0;
            end
            tr_htrans[c] = HTRANS;
            tr_haddr[c]  = HADDR;
            tr_hwdata[c] = HWDATA;
            tr_hwrite[c] = HWRITE;
            tr_busy[c]   = busy;
            tr_done[c]   = done;
            tr_error[c]  = error;
        end
        start = 1'b0;

        done_cyc = 0;
        n_done   = 0;
        n_busy   = 0;
        for (int c = 1; c <= win; c++) begin
            if (tr_done[c]) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (tr_busy[c]) n_busy++;
        end
        check("done_cycle",    done_cyc, exp_done);
        check("done_pulses",   n_done, 1);
        check("busy_cycles",   n_busy, exp_done);
        check("error_cleared", 32'(tr_error[1]), 32'd0);
        check("error_final",   32'(tr_error[exp_done]), 32'(exp_err));

        cyc = 1;
        foreach (exp_q[p]) begin
            check("htrans_addr_ph", 32'(tr_htrans[cyc]), 32'h2);
            check("haddr",          tr_haddr[cyc], exp_q[p].addr);
            check("hwrite",         32'(tr_hwrite[cyc]), 32'(exp_q[p].wr));
            cyc++;
            for (int k = 0; k <= exp_q[p].waits; k++) begin
                check("htrans_data_ph", 32'(tr_htrans[cyc]), 32'h0);
                check("haddr_held",     tr_haddr[cyc], exp_q[p].addr);
                check("hwrite_held",    32'(tr_hwrite[cyc]), 32'(exp_q[p].wr));
                if (exp_q[p].wr && !exp_q[p].err) check("hwdata", tr_hwdata[cyc], exp_q[p].data);
                cyc++;
            end
        end
        for (int c = exp_done; c <= win; c++) check("htrans_after", 32'(tr_htrans[c]), 32'h0);
        check("busy_after", 32'(tr_busy[exp_done + 1]), 32'd0);

        check("xfer_count", log_q.size() - base, exp_q.size());
        n_cmp = (log_q.size() - base < exp_q.size()) ? log_q.size() - base : exp_q.size();
        for (int i = 0; i < n_cmp; i++) begin
            check("xfer_addr", log_q[base + i].addr, exp_q[i].addr);
            check("xfer_wr",   32'(log_q[base + i].wr), 32'(exp_q[i].wr));
            check("xfer_err",  32'(log_q[base + i].err), 32'(exp_q[i].err));
            if (!exp_q[i].err) check("xfer_data", log_q[base + i].data, exp_q[i].data);
        end

        bad = 0;
        foreach (model_mem[a]) if (!mem.exists(a) || mem[a] !== model_mem[a]) bad++;
        check("mem_contents", bad, 0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] d0;
        int          n;
        int          waits;
        int          err_at;
        bit          hold;
        int          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int          mdone;
        bit          merr;
        logic [31:0] s, d;
        int          n;
        int          n_done;

        vecs[0] = '{32'h0000_0100, 32'h0000_0200, 32'hDEAD_BEEF, 1, 0, -1, 1'b0, 5,  1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_0001, 4, 0, -1, 1'b0, 17, 1'b0};
        vecs[2] = '{32'h0000_0300, 32'h0000_0400, 32'h1234_5678, 2, 2, -1, 1'b0, 17, 1'b0};
        vecs[3] = '{32'h0000_0800, 32'h0000_0900, 32'h0000_0000, 0, 0, -1, 1'b1, 1,  1'b0};
        vecs[4] = '{32'h0000_0100, 32'h0000_0200, 32'hA000_0000, 3, 0,  2, 1'b0, 8,  1'b1};
        vecs[5] = '{32'h0000_0A00, 32'h0000_0B00, 32'h5555_0000, 2, 0, -1, 1'b0, 9,  1'b0};
        vecs[6] = '{32'hFFFF_FFFE, 32'h0000_0500, 32'hCAFE_0000, 2, 0, -1, 1'b0, 9,  1'b0};
        vecs[7] = '{32'h0000_0600, 32'h0000_0700, 32'h7700_0000, 2, 1,  1, 1'b0, 7,  1'b1};

        HRESETn  = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        #22;
        check("rst_htrans", 32'(HTRANS), 32'h0);
        check("rst_haddr",  HADDR, 32'h0);
        check("rst_hwrite", 32'(HWRITE), 32'd0);
        check("rst_hwdata", HWDATA, 32'h0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_error",  32'(error), 32'd0);
        check("hsize",      32'(HSIZE), 32'h2);
        check("hburst",     32'(HBURST), 32'h0);
        check("hprot",      32'(HPROT), 32'h3);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);

        foreach (vecs[i]) begin
            cur_tag = $sformatf("vec%0d", i);
            wait_n  = vecs[i].waits;
            err_at  = vecs[i].err_at;
            preload(vecs[i].src, vecs[i].n, vecs[i].d0);
            model_mem = mem;
            build_model(vecs[i].src, vecs[i].dst, vecs[i].n, mdone, merr);
            run_and_check(vecs[i].src, vecs[i].dst, vecs[i].n, vecs[i].hold,
                          vecs[i].exp_done, vecs[i].exp_err);
        end

        // Reset asserted while the write address phase is on the bus.
        cur_tag = "reset_in_wa";
        wait_n  = 0;
        err_at  = -1;
        @(negedge HCLK);
        src_addr = 32'h0000_0C00;
        dst_addr = 32'h0000_0D00;
        len      = LEN_W'(2);
        start    = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        @(negedge HCLK);
        @(negedge HCLK);
        check("pre_htrans", 32'(HTRANS), 32'h2);
        check("pre_hwrite", 32'(HWRITE), 32'd1);
        HRESETn = 1'b0;
        #1;
        check("rst_htrans", 32'(HTRANS), 32'h0);
        check("rst_busy",   32'(busy), 32'd0);
        n_done = 0;
        if (done) n_done++;
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge HCLK);
            if (done) n_done++;
        end
        check("no_done_pulse", n_done, 0);
        check("idle_after",    32'(busy), 32'd0);

        // Randomized commands against the reference model.
        for (int r = 0; r < 24; r++) begin
            cur_tag = $sformatf("rand%0d", r);
            s = $urandom();
            if (r % 4 == 0) s = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
            d = $urandom();
            n = int'($urandom_range(0, 6));
            wait_n = int'($urandom_range(0, 2));
            err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * n)) : -1;
            preload(s, n, $urandom());
            model_mem = mem;
            build_model(s, d, n, mdone, merr);
            run_and_check(s, d, n, 1'b0, mdone, merr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
